mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Two-port arbiter and sequencer in front of the shared unified 32x4 memory/cache block. It lets the instruction-fetch port (read-only) and the load/store port (read/write) share the single memory request interface, with one transaction outstanding at a time. It handles fixed LSU priority with an anti-starvation counter, an issue pulse, response routing, and a response timeout.

Parameters:
XLEN, 32, data width of requests and responses
STARVE_MAX, 4, consecutive LSU grants allowed while IF is pending before IF is forced; range 1..15
TIMEOUT, 16, cycles waited for mem_resp_valid before an error response; range 2..255

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset; synchronous, active-low
if_req_valid  in  1  fetch request valid
if_req_ready  out  1  fetch request accepted this cycle
if_req_adr  in  32  fetch byte address
if_rsp_valid  out  1  fetch response valid, one-cycle pulse
if_rsp_data  out  XLEN  fetch read data
if_rsp_error  out  1  fetch error; qualified by if_rsp_valid
lsu_req_valid  in  1  load/store request valid
lsu_req_ready  out  1  load/store request accepted this cycle
lsu_req_we  in  1  1 = write, 0 = read
lsu_req_adr  in  32  byte address
lsu_req_data  in  XLEN  write data
lsu_req_strobe  in  4  byte enables
lsu_rsp_valid  out  1  response valid, one-cycle pulse
lsu_rsp_data  out  XLEN  read data; 0 for writes
lsu_rsp_error  out  1  error; qualified by lsu_rsp_valid
mem_r_v  out  1  memory read strobe
mem_w_v  out  1  memory write strobe
mem_adr  out  32  memory address
mem_data  out  XLEN  memory write data
mem_strobe  out  4  memory byte enables
mem_resp  in  XLEN  memory read data
mem_resp_valid  in  1  memory read data valid
mem_resp_error  in  1  memory address error

Behaviour:
- FSM states IDLE, ISSUE, WAIT, RESP. Reset forces IDLE and zeroes all outputs, the starve counter, the timeout counter, the owner register and the latched request fields.
- IDLE, grant rule:
  - Grant LSU if lsu_req_valid and not (if_req_valid and starve_cnt==STARVE_MAX); otherwise grant IF if if_req_valid.
  - Exactly one of if_req_ready/lsu_req_ready rises, combinationally, in IDLE only. The ready signal is 0 in all other states.
  - On grant: latch adr/data/strobe/we and the owner, then go to ISSUE.
  - A fetch is always a read; it is issued with mem_strobe=4'hF and mem_data=0.
- Starve counter:
  - Increments on an LSU grant while if_req_valid=1, saturating at STARVE_MAX.
  - Clears on any IF grant.
  - Clears on an LSU grant while if_req_valid=0.
- ISSUE, exactly one cycle:
  - mem_r_v or mem_w_v =1, with mem_adr/mem_data/mem_strobe driven from the latch.
  - Write: go to RESP, capturing mem_resp_error at the end of this cycle.
  - Read: go to WAIT. If mem_resp_valid is already 1 in ISSUE, capture it and go directly to RESP.
- mem_r_v/mem_w_v are high only in ISSUE. mem_adr/data/strobe hold their latched values during ISSUE and WAIT and are 0 otherwise.
- WAIT:
  - On mem_resp_valid: capture mem_resp and mem_resp_error, go to RESP.
  - The timeout counter starts at 0 on entry and increments each WAIT cycle. When it reaches TIMEOUT-1 without a response: capture data=0 and error=1, go to RESP.
- RESP, one cycle:
  - Pulse the owner's rsp_valid with the captured data/error; the other port's rsp_valid stays 0.
  - Go to IDLE. No grant occurs in RESP.
  - Minimum back-to-back throughput is one transaction every 3 cycles (IDLE→ISSUE→RESP) for writes.
- Late mem_resp_valid arriving in IDLE after a timeout is ignored.
- Reset asserted mid-transaction aborts it: no response is generated and strobes drop in the next cycle.
- Requesters must hold valid and fields stable until ready. The arbiter does not check this.

Test Plan:
- IF read 0x20010 alone; memory answers one cycle after ISSUE with data 0xDEADBEEF -> if_req_ready pulse in IDLE, mem_r_v for 1 cycle, if_rsp_valid=1 with data 0xDEADBEEF, error 0, 3 cycles after accept; lsu_rsp_valid stays 0.
- LSU write adr 0x20004, data 0x11223344, strobe 4'b0011 -> mem_w_v 1 cycle with those values; lsu_rsp_valid 2 cycles after accept, data 0, error = mem_resp_error.
- IF and LSU both held valid continuously, STARVE_MAX=4 -> grant order LSU,LSU,LSU,LSU,IF,LSU…; never more than 4 consecutive LSU grants while IF is pending.
- LSU read with memory silent, TIMEOUT=16 -> lsu_rsp_valid with error=1 and data 0 after 16 WAIT cycles; a subsequent late mem_resp_valid produces no response.
- mem_resp_error=1 on IF read of adr 0x10 -> if_rsp_error=1, then IDLE, and the next request is served normally.
- rst_n low during WAIT -> all outputs 0 next cycle, no rsp_valid. After release, an LSU grant occurs with starve_cnt=0.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Signal bundle for mem_arbiter: fetch port, load/store port and the shared memory bus.
// master is the arbiter side; slave is the requesters plus the memory.
interface mem_arbiter_if #(
    parameter int unsigned XLEN = 32
);
    logic            if_req_valid;
    logic            if_req_ready;
    logic [31:0]     if_req_adr;
    logic            if_rsp_valid;
    logic [XLEN-1:0] if_rsp_data;
    logic            if_rsp_error;
    logic            lsu_req_valid;
    logic            lsu_req_ready;
    logic            lsu_req_we;
    logic [31:0]     lsu_req_adr;
    logic [XLEN-1:0] lsu_req_data;
    logic [3:0]      lsu_req_strobe;
    logic            lsu_rsp_valid;
    logic [XLEN-1:0] lsu_rsp_data;
    logic            lsu_rsp_error;
    logic            mem_r_v;
    logic            mem_w_v;
    logic [31:0]     mem_adr;
    logic [XLEN-1:0] mem_data;
    logic [3:0]      mem_strobe;
    logic [XLEN-1:0] mem_resp;
    logic            mem_resp_valid;
    logic            mem_resp_error;

    modport master (
        input  if_req_valid, if_req_adr,
        input  lsu_req_valid, lsu_req_we, lsu_req_adr, lsu_req_data, lsu_req_strobe,
        input  mem_resp, mem_resp_valid, mem_resp_error,
        output if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_error,
        output lsu_req_ready, lsu_rsp_valid, lsu_rsp_data, lsu_rsp_error,
        output mem_r_v, mem_w_v, mem_adr, mem_data, mem_strobe
    );

    modport slave (
        output if_req_valid, if_req_adr,
        output lsu_req_valid, lsu_req_we, lsu_req_adr, lsu_req_data, lsu_req_strobe,
        output mem_resp, mem_resp_valid, mem_resp_error,
        input  if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_error,
        input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_data, lsu_rsp_error,
        input  mem_r_v, mem_w_v, mem_adr, mem_data, mem_strobe
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of the unified memory: LSU has priority, IF is forced after
// STARVE_MAX consecutive LSU grants; one transaction in flight, with a response timeout.
module mem_arbiter #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 16
) (
    input logic           clk,
    input logic           rst_n,
    mem_arbiter_if.master bus
);
    localparam logic [3:0] StarveMax   = 4'(STARVE_MAX);
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e          state_q, state_d;
    logic            owner_lsu_q, owner_lsu_d;
    logic            we_q, we_d;
    logic [31:0]     adr_q, adr_d;
    logic [XLEN-1:0] data_q, data_d;
    logic [3:0]      strobe_q, strobe_d;
    logic [3:0]      starve_q, starve_d;
    logic [7:0]      tcnt_q, tcnt_d;
    logic [XLEN-1:0] rsp_data_q, rsp_data_d;
    logic            rsp_err_q, rsp_err_d;
    logic            grant_lsu, grant_if;

    // Grants are gated by reset so no ready is visible while rst_n is low.
    assign grant_lsu = rst_n && (state_q == StIdle) && bus.lsu_req_valid &&
                       !(bus.if_req_valid && (starve_q == StarveMax));
    assign grant_if  = rst_n && (state_q == StIdle) && !grant_lsu && bus.if_req_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            owner_lsu_q <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            data_q      <= '0;
            strobe_q    <= '0;
            starve_q    <= '0;
            tcnt_q      <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_lsu_q <= owner_lsu_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            data_q      <= data_d;
            strobe_q    <= strobe_d;
            starve_q    <= starve_d;
            tcnt_q      <= tcnt_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_lsu_d = owner_lsu_q;
        we_d        = we_q;
        adr_d       = adr_q;
        data_d      = data_q;
        strobe_d    = strobe_q;
        starve_d    = starve_q;
        tcnt_d      = tcnt_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            StIdle: begin
                if (grant_lsu) begin
                    owner_lsu_d = 1'b1;
                    we_d        = bus.lsu_req_we;
                    adr_d       = bus.lsu_req_adr;
                    data_d      = bus.lsu_req_data;
                    strobe_d    = bus.lsu_req_strobe;
                    if (!bus.if_req_valid) begin
                        starve_d = '0;
                    end else if (starve_q != StarveMax) begin
                        starve_d = starve_q + 4'd1;
                    end
                    state_d = StIssue;
                end else if (grant_if) begin
                    owner_lsu_d = 1'b0;
                    we_d        = 1'b0;
                    adr_d       = bus.if_req_adr;
                    data_d      = '0;
                    strobe_d    = 4'hF;
                    starve_d    = '0;
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                tcnt_d = '0;
                if (we_q) begin
                    rsp_data_d = '0;
                    rsp_err_d  = bus.mem_resp_error;
                    state_d    = StResp;
                end else if (bus.mem_resp_valid) begin
                    rsp_data_d = bus.mem_resp;
                    rsp_err_d  = bus.mem_resp_error;
                    state_d    = StResp;
                end else begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (bus.mem_resp_valid) begin
                    rsp_data_d = bus.mem_resp;
                    rsp_err_d  = bus.mem_resp_error;
                    state_d    = StResp;
                end else if (tcnt_q == TimeoutLast) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = StResp;
                end else begin
                    tcnt_d = tcnt_q + 8'd1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.if_req_ready  = grant_if;
        bus.lsu_req_ready = grant_lsu;
        bus.if_rsp_valid  = 1'b0;
        bus.if_rsp_data   = '0;
        bus.if_rsp_error  = 1'b0;
        bus.lsu_rsp_valid = 1'b0;
        bus.lsu_rsp_data  = '0;
        bus.lsu_rsp_error = 1'b0;
        bus.mem_r_v       = 1'b0;
        bus.mem_w_v       = 1'b0;
        bus.mem_adr       = '0;
        bus.mem_data      = '0;
        bus.mem_strobe    = '0;
        case (state_q)
            StIssue, StWait: begin
                bus.mem_r_v    = (state_q == StIssue) && !we_q;
                bus.mem_w_v    = (state_q == StIssue) && we_q;
                bus.mem_adr    = adr_q;
                bus.mem_data   = data_q;
                bus.mem_strobe = strobe_q;
            end
            StResp: begin
                if (owner_lsu_q) begin
                    bus.lsu_rsp_valid = 1'b1;
                    bus.lsu_rsp_data  = rsp_data_q;
                    bus.lsu_rsp_error = rsp_err_q;
                end else begin
                    bus.if_rsp_valid = 1'b1;
                    bus.if_rsp_data  = rsp_data_q;
                    bus.if_rsp_error = rsp_err_q;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: scoreboard of expected responses, a small
// behavioural memory with programmable latency/error, and one task per scenario.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    mem_arbiter_if #(.XLEN(32)) bus ();

    mem_arbiter #(
        .XLEN       (32),
        .STARVE_MAX (4),
        .TIMEOUT    (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        if_ready, lsu_ready;
        logic        if_rv, if_re, lsu_rv, lsu_re;
        logic [31:0] if_rd, lsu_rd;
        logic        r_v, w_v;
        logic [31:0] adr, data;
        logic [3:0]  strobe;
        logic        any;
        int          cyc;
    } snap_t;

    typedef struct {
        bit          lsu;
        logic [31:0] data;
        bit          err;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    // Memory model: mem_lat < 0 means silent, 0 answers during ISSUE, n answers n cycles later.
    int          mem_lat = 1;
    logic [31:0] mem_rdata = '0;
    logic        mem_err = 1'b0;
    logic        late_pulse = 1'b0;
    int          cd = -1;
    logic        model_v;

    always @(negedge clk) begin
        model_v = 1'b0;
        if (cd == 0) begin
            model_v = 1'b1;
            cd = -1;
        end else if (cd > 0) begin
            cd--;
        end
        if (bus.mem_r_v && mem_lat == 0) model_v = 1'b1;
        else if (bus.mem_r_v && mem_lat > 0) cd = mem_lat - 1;
        bus.mem_resp_valid = model_v | late_pulse;
        bus.mem_resp       = mem_rdata;
        bus.mem_resp_error = mem_err;
    end

    function automatic snap_t snap();
        snap_t s;
        s.if_ready  = bus.if_req_ready;
        s.lsu_ready = bus.lsu_req_ready;
        s.if_rv     = bus.if_rsp_valid;
        s.if_rd     = bus.if_rsp_data;
        s.if_re     = bus.if_rsp_error;
        s.lsu_rv    = bus.lsu_rsp_valid;
        s.lsu_rd    = bus.lsu_rsp_data;
        s.lsu_re    = bus.lsu_rsp_error;
        s.r_v       = bus.mem_r_v;
        s.w_v       = bus.mem_w_v;
        s.adr       = bus.mem_adr;
        s.data      = bus.mem_data;
        s.strobe    = bus.mem_strobe;
        s.any = |{bus.if_req_ready, bus.lsu_req_ready, bus.if_rsp_valid, bus.if_rsp_data,
                  bus.if_rsp_error, bus.lsu_rsp_valid, bus.lsu_rsp_data, bus.lsu_rsp_error,
                  bus.mem_r_v, bus.mem_w_v, bus.mem_adr, bus.mem_data, bus.mem_strobe};
        s.cyc = cyc;
        return s;
    endfunction

    task automatic step(output snap_t s);
        @(negedge clk);
        #1;
        s = snap();
    endtask

    // Presents one request, waits (bounded) for its ready, returns the accept cycle
    // (-1 if never accepted) and the snapshot of the following (ISSUE) cycle.
    task automatic req(input bit lsu, input bit we, input logic [31:0] adr,
                       input logic [31:0] data, input logic [3:0] strb,
                       output int acc, output snap_t s_issue);
        snap_t s;
        acc = -1;
        if (lsu) begin
            bus.lsu_req_we     = we;
            bus.lsu_req_adr    = adr;
            bus.lsu_req_data   = data;
            bus.lsu_req_strobe = strb;
            bus.lsu_req_valid  = 1'b1;
        end else begin
            bus.if_req_adr   = adr;
            bus.if_req_valid = 1'b1;
        end
        #1;
        for (int i = 0; i < 20 && acc < 0; i++) begin
            if (lsu ? bus.lsu_req_ready : bus.if_req_ready) acc = cyc;
            else step(s);
        end
        step(s_issue);
        bus.lsu_req_valid = 1'b0;
        bus.if_req_valid  = 1'b0;
    endtask

    task automatic test_reset();
        snap_t s;
        rst_n = 1'b0;
        repeat (3) step(s);
        n_cmp++;
        if (s.any !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got any_output=%b required 0", s.any);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_if_read();
        snap_t s;
        exp_t e;
        logic [66:0] got, want;
        int acc, nr;
        sb.delete();
        mem_lat = 1; mem_rdata = 32'hDEAD_BEEF; mem_err = 1'b0;
        req(1'b0, 1'b0, 32'h0002_0010, 32'h0, 4'h0, acc, s);
        n_cmp++;
        if (acc < 0) begin
            n_bad++;
            $display("FAIL if_read_accept: got no if_req_ready required a grant");
        end else sb.push_back('{1'b0, 32'hDEAD_BEEF, 1'b0, acc + 3});
        nr = 0;
        for (int i = 0; i < 8; i++) begin
            if (s.r_v || s.w_v) begin
                nr++;
                n_cmp++;
                if ({s.w_v, s.adr, s.data, s.strobe} !== {1'b0, 32'h0002_0010, 32'h0, 4'hF}) begin
                    n_bad++;
                    $display("FAIL if_read_bus: got w=%b adr=%h data=%h strb=%h required w=0 adr=00020010 data=0 strb=f",
                             s.w_v, s.adr, s.data, s.strobe);
                end
            end
            if (s.if_rv || s.lsu_rv) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL if_read_rsp: got a response at cycle %0d required none", s.cyc);
                end else begin
                    e = sb.pop_front();
                    got  = {s.lsu_rv, s.if_rv, s.lsu_rv ? s.lsu_rd : s.if_rd,
                            s.lsu_rv ? s.lsu_re : s.if_re, s.cyc};
                    want = {e.lsu, !e.lsu, e.data, e.err, e.cyc};
                    if (got !== want) begin
                        n_bad++;
                        $display("FAIL if_read_rsp: got %h required %h", got, want);
                    end
                end
            end
            step(s);
        end
        n_cmp++;
        if (nr !== 1) begin
            n_bad++;
            $display("FAIL if_read_strobe: got %0d mem_r_v cycles required 1", nr);
        end
        n_cmp++;
        if ({sb.size(), s.adr} !== {32'd0, 32'h0}) begin
            n_bad++;
            $display("FAIL if_read_drain: got %0d pending adr=%h required 0 pending adr=0",
                     sb.size(), s.adr);
        end
    endtask

    task automatic test_lsu_write();
        snap_t s;
        exp_t e;
        logic [66:0] got, want;
        int acc;
        sb.delete();
        for (int k = 0; k < 2; k++) begin
            mem_err = (k == 1);
            req(1'b1, 1'b1, 32'h0002_0004, 32'h1122_3344, 4'b0011, acc, s);
            n_cmp++;
            if (acc < 0) begin
                n_bad++;
                $display("FAIL lsu_write_accept: got no lsu_req_ready required a grant");
            end else sb.push_back('{1'b1, 32'h0, (k == 1), acc + 2});
            n_cmp++;
            if ({s.r_v, s.w_v, s.adr, s.data, s.strobe} !==
                {1'b0, 1'b1, 32'h0002_0004, 32'h1122_3344, 4'b0011}) begin
                n_bad++;
                $display("FAIL lsu_write_bus: got r=%b w=%b adr=%h data=%h strb=%h required r=0 w=1 adr=00020004 data=11223344 strb=3",
                         s.r_v, s.w_v, s.adr, s.data, s.strobe);
            end
            for (int i = 0; i < 4; i++) begin
                if (s.if_rv || s.lsu_rv) begin
                    n_cmp++;
                    if (sb.size() == 0) begin
                        n_bad++;
                        $display("FAIL lsu_write_rsp: got a response at cycle %0d required none", s.cyc);
                    end else begin
                        e = sb.pop_front();
                        got  = {s.lsu_rv, s.if_rv, s.lsu_rv ? s.lsu_rd : s.if_rd,
                                s.lsu_rv ? s.lsu_re : s.if_re, s.cyc};
                        want = {e.lsu, !e.lsu, e.data, e.err, e.cyc};
                        if (got !== want) begin
                            n_bad++;
                            $display("FAIL lsu_write_rsp: got %h required %h", got, want);
                        end
                    end
                end
                step(s);
            end
        end
        mem_err = 1'b0;
        n_cmp++;
        if (sb.size() !== 0) begin
            n_bad++;
            $display("FAIL lsu_write_drain: got %0d pending required 0", sb.size());
        end
    endtask

    task automatic test_starve();
        snap_t s;
        exp_t e;
        logic [66:0] got, want;
        int g = 0;
        bit drop = 1'b0;
        bit lsu_g;
        sb.delete();
        mem_lat = 1; mem_rdata = 32'h0BAD_F00D; mem_err = 1'b0;
        bus.if_req_adr     = 32'h100;
        bus.lsu_req_we     = 1'b1;
        bus.lsu_req_adr    = 32'h200;
        bus.lsu_req_data   = 32'hA5A5_A5A5;
        bus.lsu_req_strobe = 4'hF;
        bus.if_req_valid   = 1'b1;
        bus.lsu_req_valid  = 1'b1;
        #1;
        s = snap();
        for (int i = 0; i < 45; i++) begin
            if (s.if_ready || s.lsu_ready) begin
                lsu_g = (g % 5) != 4;
                n_cmp++;
                if ({s.lsu_ready, s.if_ready} !== {lsu_g, !lsu_g}) begin
                    n_bad++;
                    $display("FAIL starve_grant%0d: got lsu/if ready=%b%b required %b%b",
                             g, s.lsu_ready, s.if_ready, lsu_g, !lsu_g);
                end
                if (lsu_g) sb.push_back('{1'b1, 32'h0, 1'b0, s.cyc + 2});
                else sb.push_back('{1'b0, 32'h0BAD_F00D, 1'b0, s.cyc + 3});
                g++;
                drop = (g == 10);
            end
            if (s.if_rv || s.lsu_rv) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL starve_rsp: got a response at cycle %0d required none", s.cyc);
                end else begin
                    e = sb.pop_front();
                    got  = {s.lsu_rv, s.if_rv, s.lsu_rv ? s.lsu_rd : s.if_rd,
                            s.lsu_rv ? s.lsu_re : s.if_re, s.cyc};
                    want = {e.lsu, !e.lsu, e.data, e.err, e.cyc};
                    if (got !== want) begin
                        n_bad++;
                        $display("FAIL starve_rsp: got %h required %h", got, want);
                    end
                end
            end
            step(s);
            if (drop) begin
                bus.if_req_valid  = 1'b0;
                bus.lsu_req_valid = 1'b0;
                drop = 1'b0;
            end
        end
        bus.if_req_valid  = 1'b0;
        bus.lsu_req_valid = 1'b0;
        n_cmp++;
        if ({g, sb.size()} !== {32'd10, 32'd0}) begin
            n_bad++;
            $display("FAIL starve_drain: got %0d grants %0d pending required 10 grants 0 pending",
                     g, sb.size());
        end
    endtask

    task automatic test_timeout();
        snap_t s;
        exp_t e;
        logic [66:0] got, want;
        int acc, nlate;
        sb.delete();
        mem_lat = -1; mem_rdata = 32'h7777_7777; mem_err = 1'b0;
        req(1'b1, 1'b0, 32'h0003_0000, 32'h0, 4'hF, acc, s);
        n_cmp++;
        if (acc < 0) begin
            n_bad++;
            $display("FAIL timeout_accept: got no lsu_req_ready required a grant");
        end else sb.push_back('{1'b1, 32'h0, 1'b1, acc + 18});
        for (int i = 0; i < 22; i++) begin
            if (i == 10) begin
                n_cmp++;
                if ({s.r_v, s.adr, s.strobe} !== {1'b0, 32'h0003_0000, 4'hF}) begin
                    n_bad++;
                    $display("FAIL timeout_hold: got r=%b adr=%h strb=%h required r=0 adr=00030000 strb=f",
                             s.r_v, s.adr, s.strobe);
                end
            end
            if (s.if_rv || s.lsu_rv) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL timeout_rsp: got a response at cycle %0d required none", s.cyc);
                end else begin
                    e = sb.pop_front();
                    got  = {s.lsu_rv, s.if_rv, s.lsu_rv ? s.lsu_rd : s.if_rd,
                            s.lsu_rv ? s.lsu_re : s.if_re, s.cyc};
                    want = {e.lsu, !e.lsu, e.data, e.err, e.cyc};
                    if (got !== want) begin
                        n_bad++;
                        $display("FAIL timeout_rsp: got %h required %h", got, want);
                    end
                end
            end
            step(s);
        end
        n_cmp++;
        if (sb.size() !== 0) begin
            n_bad++;
            $display("FAIL timeout_drain: got %0d pending required 0", sb.size());
        end
        late_pulse = 1'b1;
        step(s);
        late_pulse = 1'b0;
        nlate = 0;
        for (int i = 0; i < 5; i++) begin
            step(s);
            if (s.if_rv || s.lsu_rv || s.r_v || s.w_v) nlate++;
        end
        n_cmp++;
        if (nlate !== 0) begin
            n_bad++;
            $display("FAIL late_resp: got %0d active cycles after late mem_resp_valid required 0",
                     nlate);
        end
    endtask

    task automatic test_error_then_normal();
        snap_t s;
        exp_t e;
        logic [66:0] got, want;
        int acc;
        sb.delete();
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                mem_lat = 1; mem_rdata = 32'h55; mem_err = 1'b1;
                req(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, acc, s);
            end else begin
                mem_lat = 0; mem_rdata = 32'hCAFE_F00D; mem_err = 1'b0;
                req(1'b1, 1'b0, 32'h40, 32'h0, 4'hF, acc, s);
            end
            n_cmp++;
            if (acc < 0) begin
                n_bad++;
                $display("FAIL error_accept%0d: got no ready required a grant", k);
            end else if (k == 0) sb.push_back('{1'b0, 32'h55, 1'b1, acc + 3});
            else sb.push_back('{1'b1, 32'hCAFE_F00D, 1'b0, acc + 2});
            for (int i = 0; i < 5; i++) begin
                if (s.if_rv || s.lsu_rv) begin
                    n_cmp++;
                    if (sb.size() == 0) begin
                        n_bad++;
                        $display("FAIL error_rsp: got a response at cycle %0d required none", s.cyc);
                    end else begin
                        e = sb.pop_front();
                        got  = {s.lsu_rv, s.if_rv, s.lsu_rv ? s.lsu_rd : s.if_rd,
                                s.lsu_rv ? s.lsu_re : s.if_re, s.cyc};
                        want = {e.lsu, !e.lsu, e.data, e.err, e.cyc};
                        if (got !== want) begin
                            n_bad++;
                            $display("FAIL error_rsp%0d: got %h required %h", k, got, want);
                        end
                    end
                end
                step(s);
            end
        end
        n_cmp++;
        if (sb.size() !== 0) begin
            n_bad++;
            $display("FAIL error_drain: got %0d pending required 0", sb.size());
        end
    endtask

    task automatic test_reset_mid();
        snap_t s;
        exp_t e;
        logic [66:0] got, want;
        int g = 0;
        int after = -1;
        bit drop = 1'b0;
        bit lsu_g;
        sb.delete();
        mem_lat = -1; mem_err = 1'b0;
        bus.if_req_adr     = 32'h300;
        bus.lsu_req_we     = 1'b1;
        bus.lsu_req_adr    = 32'h400;
        bus.lsu_req_data   = 32'h1;
        bus.lsu_req_strobe = 4'hF;
        bus.if_req_valid   = 1'b1;
        bus.lsu_req_valid  = 1'b1;
        #1;
        s = snap();
        // Three LSU writes then an LSU read left hanging in WAIT, all with IF pending.
        for (int i = 0; i < 30 && after != 2; i++) begin
            if (s.if_ready || s.lsu_ready) begin
                n_cmp++;
                if ({s.lsu_ready, s.if_ready} !== 2'b10) begin
                    n_bad++;
                    $display("FAIL pre_reset_grant%0d: got lsu/if ready=%b%b required 10",
                             g, s.lsu_ready, s.if_ready);
                end
                g++;
                if (g < 4) sb.push_back('{1'b1, 32'h0, 1'b0, s.cyc + 2});
                if (g == 4) after = 0;
            end
            if (s.lsu_rv || s.if_rv) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL pre_reset_rsp: got a response at cycle %0d required none", s.cyc);
                end else begin
                    e = sb.pop_front();
                    got  = {s.lsu_rv, s.if_rv, s.lsu_rv ? s.lsu_rd : s.if_rd,
                            s.lsu_rv ? s.lsu_re : s.if_re, s.cyc};
                    want = {e.lsu, !e.lsu, e.data, e.err, e.cyc};
                    if (got !== want) begin
                        n_bad++;
                        $display("FAIL pre_reset_rsp: got %h required %h", got, want);
                    end
                end
            end
            step(s);
            if (after >= 0) after++;
            if (g == 3) bus.lsu_req_we = 1'b0;
        end
        n_cmp++;
        if ({g, sb.size()} !== {32'd4, 32'd0}) begin
            n_bad++;
            $display("FAIL pre_reset_state: got %0d grants %0d pending required 4 grants 0 pending",
                     g, sb.size());
        end
        rst_n = 1'b0;
        bus.lsu_req_we = 1'b1;
        mem_lat = 1; mem_rdata = 32'h1234_5678;
        for (int i = 0; i < 2; i++) begin
            step(s);
            n_cmp++;
            if (s.any !== 1'b0) begin
                n_bad++;
                $display("FAIL mid_reset_outputs%0d: got any_output=%b required 0", i, s.any);
            end
        end
        rst_n = 1'b1;
        #1;
        s = snap();
        g = 0;
        for (int i = 0; i < 30; i++) begin
            if (s.if_ready || s.lsu_ready) begin
                lsu_g = (g < 4);
                n_cmp++;
                if ({s.lsu_ready, s.if_ready} !== {lsu_g, !lsu_g}) begin
                    n_bad++;
                    $display("FAIL post_reset_grant%0d: got lsu/if ready=%b%b required %b%b",
                             g, s.lsu_ready, s.if_ready, lsu_g, !lsu_g);
                end
                if (lsu_g) sb.push_back('{1'b1, 32'h0, 1'b0, s.cyc + 2});
                else sb.push_back('{1'b0, 32'h1234_5678, 1'b0, s.cyc + 3});
                g++;
                drop = (g == 5);
            end
            if (s.lsu_rv || s.if_rv) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL post_reset_rsp: got a response at cycle %0d required none", s.cyc);
                end else begin
                    e = sb.pop_front();
                    got  = {s.lsu_rv, s.if_rv, s.lsu_rv ? s.lsu_rd : s.if_rd,
                            s.lsu_rv ? s.lsu_re : s.if_re, s.cyc};
                    want = {e.lsu, !e.lsu, e.data, e.err, e.cyc};
                    if (got !== want) begin
                        n_bad++;
                        $display("FAIL post_reset_rsp: got %h required %h", got, want);
                    end
                end
            end
            step(s);
            if (drop) begin
                bus.if_req_valid  = 1'b0;
                bus.lsu_req_valid = 1'b0;
                drop = 1'b0;
            end
        end
        bus.if_req_valid  = 1'b0;
        bus.lsu_req_valid = 1'b0;
        n_cmp++;
        if ({g, sb.size()} !== {32'd5, 32'd0}) begin
            n_bad++;
            $display("FAIL post_reset_drain: got %0d grants %0d pending required 5 grants 0 pending",
                     g, sb.size());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion by %0t required finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.if_req_valid   = 1'b0;
        bus.if_req_adr     = '0;
        bus.lsu_req_valid  = 1'b0;
        bus.lsu_req_we     = 1'b0;
        bus.lsu_req_adr    = '0;
        bus.lsu_req_data   = '0;
        bus.lsu_req_strobe = '0;
        bus.mem_resp       = '0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_error = 1'b0;
        test_reset();
        test_if_read();
        test_lsu_write();
        test_starve();
        test_timeout();
        test_error_then_normal();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
